// File: rtl/cpu_pkg.sv
// Shared definitions for the elementary CPU: opcodes, ALU codes, sequencer states,
// register-file write polarity and the decoded-instruction struct.
package cpu_pkg;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_MOV  = 4'h1;
   localparam logic [3:0] OP_ADD  = 4'h2;
   localparam logic [3:0] OP_SUB  = 4'h3;
   localparam logic [3:0] OP_AND  = 4'h4;
   localparam logic [3:0] OP_OR   = 4'h5;
   localparam logic [3:0] OP_NOT  = 4'h6;
   localparam logic [3:0] OP_SHL  = 4'h7;
   localparam logic [3:0] OP_JMP  = 4'h8;
   localparam logic [3:0] OP_JZ   = 4'h9;
   localparam logic [3:0] OP_LDI  = 4'hA;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [2:0] ALU_PASS = 3'b000;
   localparam logic [2:0] ALU_ADD  = 3'b001;
   localparam logic [2:0] ALU_SUB  = 3'b010;
   localparam logic [2:0] ALU_AND  = 3'b011;
   localparam logic [2:0] ALU_OR   = 3'b100;
   localparam logic [2:0] ALU_NOT  = 3'b101;
   localparam logic [2:0] ALU_SHL  = 3'b110;

   localparam logic RF_WE_ACTIVE = 1'b0;

   typedef enum logic [2:0] {FETCH, OPND, EXEC, WAIT, HALT} seq_state_t;

   typedef struct packed {
      logic [1:0] rsa;
      logic [1:0] rwda;
      logic [2:0] alu_op;
      logic       isel;
      logic       writes_rf;
      logic       two_byte;
      logic       updates_z;
   } dec_t;

   // Ops that carry an operand byte right after the opcode byte.
   function automatic logic is_two_byte(input logic [3:0] op);
      return (op == OP_JMP) || (op == OP_JZ) || (op == OP_LDI);
   endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Sequencer <-> ROM / register-file / ALU signal bundle.
// SEQ_SINGLE_STEP_EN adds the 'step' input.
interface instr_sequencer_if #(parameter int PC_W = 8);
   logic [7:0]      ins;
   logic            zf;
`ifdef SEQ_SINGLE_STEP_EN
   logic            step;
`endif
   logic [PC_W-1:0] pc;
   logic [1:0]      RSA;
   logic [1:0]      RWDA;
   logic            we;
   logic [2:0]      alu_op;
   logic            isel;
   logic [7:0]      imm;
   logic            halted;

`ifdef SEQ_SINGLE_STEP_EN
   modport master (input ins, zf, step,
                   output pc, RSA, RWDA, we, alu_op, isel, imm, halted);
   modport slave  (output ins, zf, step,
                   input pc, RSA, RWDA, we, alu_op, isel, imm, halted);
`else
   modport master (input ins, zf,
                   output pc, RSA, RWDA, we, alu_op, isel, imm, halted);
   modport slave  (output ins, zf,
                   input pc, RSA, RWDA, we, alu_op, isel, imm, halted);
`endif
endinterface

// File: rtl/instr_sequencer_decode.sv
// Combinational instruction decode: ir -> register selects, ALU op, write-data mux
// and per-op control flags.
module ir_decode
   import cpu_pkg::*;
(
   input  logic [7:0] ir,
   output dec_t       dec
);

   always_comb begin
      dec           = '0;
      dec.rsa       = ir[3:2];
      dec.rwda      = ir[1:0];
      dec.two_byte  = is_two_byte(ir[7:4]);
      case (ir[7:4])
         OP_MOV: dec.writes_rf = 1'b1;
         OP_ADD: begin dec.writes_rf = 1'b1; dec.updates_z = 1'b1; dec.alu_op = ALU_ADD; end
         OP_SUB: begin dec.writes_rf = 1'b1; dec.updates_z = 1'b1; dec.alu_op = ALU_SUB; end
         OP_AND: begin dec.writes_rf = 1'b1; dec.updates_z = 1'b1; dec.alu_op = ALU_AND; end
         OP_OR:  begin dec.writes_rf = 1'b1; dec.updates_z = 1'b1; dec.alu_op = ALU_OR;  end
         OP_NOT: begin dec.writes_rf = 1'b1; dec.updates_z = 1'b1; dec.alu_op = ALU_NOT; end
         OP_SHL: begin dec.writes_rf = 1'b1; dec.updates_z = 1'b1; dec.alu_op = ALU_SHL; end
         OP_LDI: begin dec.writes_rf = 1'b1; dec.isel = 1'b1; end
         default: ;
      endcase
   end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer for the elementary CPU: owns pc, ir, imm and Z.
// Optional feature macro: SEQ_SINGLE_STEP_EN (WAIT state gated by 'step').
module instr_sequencer
   import cpu_pkg::*;
#(
   parameter int              PC_W   = 8,
   parameter logic [PC_W-1:0] RST_PC = '0
) (
   input  logic                clk,
   input  logic                rst,
   instr_sequencer_if.master   bus
);

   seq_state_t      state, state_nxt;
   logic [PC_W-1:0] pc, pc_nxt;
   logic [7:0]      ir, ir_nxt;
   logic [7:0]      imm, imm_nxt;
   logic            z_flag, z_nxt;
   logic            we;
   dec_t            dec;

   ir_decode u_dec (.ir(ir), .dec(dec));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= FETCH;
         pc     <= RST_PC;
         ir     <= 8'h00;
         imm    <= 8'h00;
         z_flag <= 1'b0;
      end else begin
         state  <= state_nxt;
         pc     <= pc_nxt;
         ir     <= ir_nxt;
         imm    <= imm_nxt;
         z_flag <= z_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      ir_nxt    = ir;
      imm_nxt   = imm;
      z_nxt     = z_flag;
      we        = ~RF_WE_ACTIVE;
      case (state)
         FETCH: begin
            ir_nxt    = bus.ins;
            pc_nxt    = pc + 1'b1;
            state_nxt = is_two_byte(bus.ins[7:4]) ? OPND : EXEC;
         end
         OPND: begin
            imm_nxt   = bus.ins;
            pc_nxt    = pc + 1'b1;
            state_nxt = EXEC;
         end
         EXEC: begin
            if (dec.writes_rf) we = RF_WE_ACTIVE;
            if (dec.updates_z) z_nxt = bus.zf;
            // Branch targets come from the operand byte, so only two-byte ops branch.
            if (dec.two_byte && ir[7:4] == OP_JMP) pc_nxt = PC_W'(imm);
            if (dec.two_byte && ir[7:4] == OP_JZ && z_flag) pc_nxt = PC_W'(imm);
`ifdef SEQ_SINGLE_STEP_EN
            state_nxt = (ir[7:4] == OP_HALT) ? HALT : WAIT;
`else
            state_nxt = (ir[7:4] == OP_HALT) ? HALT : FETCH;
`endif
         end
         WAIT: begin
`ifdef SEQ_SINGLE_STEP_EN
            if (bus.step) state_nxt = FETCH;
`else
            state_nxt = FETCH;
`endif
         end
         HALT:    state_nxt = HALT;
         default: state_nxt = FETCH;
      endcase
   end

   assign bus.pc     = pc;
   assign bus.RSA    = dec.rsa;
   assign bus.RWDA   = dec.rwda;
   assign bus.alu_op = dec.alu_op;
   assign bus.isel   = dec.isel;
   assign bus.imm    = imm;
   assign bus.we     = we;
   assign bus.halted = (state == HALT);

endmodule
